alu_seq: RTL
============

# alu_seq

Registered, parameterised arithmetic/logic unit with a start/done handshake. It generalises the combinational add/subtract ALU to eight operations, adds negative and signed-overflow flags, and adds an optional multi-cycle shift-add multiplier. It sits between the A/B registers and the bus in the SAP datapath, stepped by the shared `mclk_en` strobe. The control decoder pulses `i_start` and waits for `o_done`.

## Interface
- `WIDTH`, default 8: operand and result width. Must be a power of two and at least 4.
- `mclk  in  1`: master clock.
- `rst_n  in  1`: asynchronous, active-low reset.
- `mclk_en  in  1`: clock enable. All state advances only on `mclk` edges where `mclk_en`=1 ("enabled edges").
- `i_start  in  1`: request an operation. Sampled on enabled edges.
- `i_op  in  3`: opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL/CMP (see Configuration).
- `i_latch_flags  in  1`: update the flags when this operation completes.
- `i_a`, `i_b`  in  WIDTH: operands.
- `o_data  out  WIDTH`: registered result.
- `o_busy  out  1`: a multi-cycle operation is in progress.
- `o_done  out  1`: completion pulse.
- `o_zero`, `o_carry`, `o_odd`, `o_negative`, `o_overflow`  out  1: registered flags.

## Operation
- **States:** IDLE and MUL.
- **Reset:** asynchronous reset forces IDLE and drives every output and internal register to 0. Reset during MUL aborts the operation with no `o_done`.
- **Start acceptance:** `i_start` is accepted on an enabled edge in IDLE. In MUL it is ignored and is not queued.
- **Single-cycle ops (0-6):** at the accepting edge, the result is written to `o_data` and `o_done` is set. The unit stays in IDLE.
- **ADD/SUB:**
  - Result is computed in WIDTH+1 bits.
  - `carry` = bit WIDTH. For SUB this is the borrow: 1 iff `i_a` < `i_b` unsigned.
  - `overflow` = two's-complement signed overflow.
- **AND/OR/XOR:** bitwise. `carry` = 0, `overflow` = 0.
- **SHL/SHR:**
  - Logical shift of `i_a` by `i_b[clog2(WIDTH)-1:0]`.
  - `carry` = last bit shifted out; 0 when the shift amount is 0.
  - `overflow` = 0.
- **Flags:**
  - Common to all ops: `zero` = (result==0), `odd` = result[0], `negative` = result[WIDTH-1].
  - Flags update only when the latch-flags bit captured at start was 1. Otherwise they hold their values.
- **MUL:**
  - Operands and `i_latch_flags` are captured at the accepting edge, and the unit goes to MUL.
  - One shift-add step runs per enabled edge into a 2*WIDTH accumulator, with a counter running 0..WIDTH-1.
  - On the WIDTH-th enabled edge after acceptance: `o_data` = low WIDTH bits of the product, `carry` = (high half ≠ 0), `overflow` = 0, state returns to IDLE, and `o_done` is set.
- **Stable output:** `o_data` changes only at completion edges.

## Timing
- `o_done`:
  - Set at the completion edge, cleared at the next enabled edge.
  - It is therefore high for exactly one enabled cycle, and longer in real time if `mclk_en` stalls.
  - A new start accepted at that same next edge re-asserts it, so back-to-back single-cycle ops give a continuous `o_done`.
- Single-cycle ops: latency is 1 enabled edge. `o_busy` stays 0.
- MUL:
  - `o_busy` is 1 from the accepting edge until the completion edge, i.e. WIDTH enabled cycles.
  - A new start is accepted at the first enabled edge after completion.
- `mclk_en`=0: all registers hold, including the MUL counter and `o_done`.
- Inputs other than `i_start`/`i_op` are don't-care while busy.

## Configuration
- `ALU_MUL_EN` defined:
  - Opcode 7 = MUL, as described above.
  - The accumulator, counter and MUL state are built.
- Not defined:
  - Opcode 7 = CMP: a single-cycle SUB that updates the flags (subject to `i_latch_flags`) but leaves `o_data` unchanged, and still pulses `o_done`.
  - No MUL logic is built. `o_busy` is tied to 0.

## Test plan
All scenarios use WIDTH=8.
- **Reset:** assert `rst_n`=0 mid-run → all outputs 0 immediately, without waiting for a clock edge.
- **ADD:** 200+100 with latch=1 → `o_data`=44, carry=1, overflow=0, zero=0, negative=0. Then ADD 127+1 → 128, overflow=1, negative=1, carry=0. `o_done` is high one cycle each.
- **SUB, SHL and flag hold:**
  - SUB 5−7 → 254, carry=1, negative=1, odd=0.
  - SHL 0x81 by 1 → 0x02, carry=1.
  - AND 0xF0&0x0F with latch=0 → `o_data`=0, flags unchanged (zero stays 0).
- **MUL (`ALU_MUL_EN`):**
  - 15×17 → 255 after 8 enabled edges, busy high 8 cycles, carry=0.
  - 16×16 → 0, zero=1, carry=1.
  - `i_start` pulsed during busy → ignored; exactly one `o_done`.
- **`mclk_en` stall:** toggle `mclk_en` 1-in-3 during MUL → result and flags identical to the unstalled run, completing after 8 enabled edges. Reset at the 4th enabled edge → busy=0, no `o_done`, `o_data`=0.
- **CMP (no `ALU_MUL_EN`):** op 7 with `o_data` holding 0x2C, 3 vs 3 → `o_data` stays 0x2C, zero=1, carry=0, `o_done` pulses, `o_busy` never asserts.

Source files
------------

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// alu_seq : registered 8-op ALU with start/done handshake and flags.
// Optional shift-add multiplier on opcode 7 when ALU_MUL_EN is defined
// (otherwise opcode 7 is CMP).  Revision: 1.0
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             mclk,
    input  logic             rst_n,
    input  logic             mclk_en,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic             i_latch_flags,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_data,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_zero,
    output logic             o_carry,
    output logic             o_odd,
    output logic             o_negative,
    output logic             o_overflow
);

    localparam int SW = $clog2(WIDTH);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   shl_ext;
    logic [WIDTH:0]   shr_ext;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_ovf;
    logic             single_go;
    logic             single_wr;

    // Shifts carry one guard bit so the last bit shifted out falls into it.
    always_comb begin
        shamt     = i_b[SW-1:0];
        sum       = {1'b0, i_a} + {1'b0, i_b};
        diff      = {1'b0, i_a} - {1'b0, i_b};
        shl_ext   = {1'b0, i_a} << shamt;
        shr_ext   = {i_a, 1'b0} >> shamt;
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (i_op)
            3'd0: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
                alu_ovf   = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            3'd1, 3'd7: begin
                alu_res   = diff[WIDTH-1:0];
                alu_carry = diff[WIDTH];
                alu_ovf   = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (diff[WIDTH-1] != i_a[WIDTH-1]);
            end
            3'd2: alu_res = i_a & i_b;
            3'd3: alu_res = i_a | i_b;
            3'd4: alu_res = i_a ^ i_b;
            3'd5: begin
                alu_res   = shl_ext[WIDTH-1:0];
                alu_carry = shl_ext[WIDTH];
            end
            3'd6: begin
                alu_res   = shr_ext[WIDTH:1];
                alu_carry = shr_ext[0];
            end
            default: ;
        endcase
    end

`ifdef ALU_MUL_EN
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   mplier;
    logic [SW-1:0]      cnt;
    logic               mul_latch;
    logic               mul_go;
    logic               mul_last;

    always_comb begin
        single_go = (state == IDLE) && i_start && (i_op != 3'd7);
        single_wr = 1'b1;
        mul_go    = (state == IDLE) && i_start && (i_op == 3'd7);
        mul_last  = (state == MUL) && (cnt == SW'(WIDTH - 1));
        acc_step  = acc + (mplier[0] ? mcand : '0);
        state_nxt = state;
        case (state)
            IDLE:    if (mul_go)   state_nxt = MUL;
            MUL:     if (mul_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else if (mclk_en)
            state <= state_nxt;
    end

    assign o_busy = (state == MUL);
`else
    // CMP shares the SUB datapath but never writes the result register.
    always_comb begin
        single_go = i_start;
        single_wr = (i_op != 3'd7);
    end

    assign o_busy = 1'b0;
`endif

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            o_data     <= '0;
            o_done     <= 1'b0;
            o_zero     <= 1'b0;
            o_carry    <= 1'b0;
            o_odd      <= 1'b0;
            o_negative <= 1'b0;
            o_overflow <= 1'b0;
`ifdef ALU_MUL_EN
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            cnt        <= '0;
            mul_latch  <= 1'b0;
`endif
        end else if (mclk_en) begin
            o_done <= 1'b0;
            if (single_go) begin
                o_done <= 1'b1;
                if (single_wr)
                    o_data <= alu_res;
                if (i_latch_flags) begin
                    o_zero     <= (alu_res == '0);
                    o_carry    <= alu_carry;
                    o_odd      <= alu_res[0];
                    o_negative <= alu_res[WIDTH-1];
                    o_overflow <= alu_ovf;
                end
            end
`ifdef ALU_MUL_EN
            if (mul_go) begin
                acc       <= '0;
                mcand     <= {{WIDTH{1'b0}}, i_a};
                mplier    <= i_b;
                cnt       <= '0;
                mul_latch <= i_latch_flags;
            end else if (state == MUL) begin
                acc    <= acc_step;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                if (mul_last) begin
                    o_data <= acc_step[WIDTH-1:0];
                    o_done <= 1'b1;
                    if (mul_latch) begin
                        o_zero     <= (acc_step[WIDTH-1:0] == '0);
                        o_carry    <= |acc_step[2*WIDTH-1:WIDTH];
                        o_odd      <= acc_step[0];
                        o_negative <= acc_step[WIDTH-1];
                        o_overflow <= 1'b0;
                    end
                end
            end
`endif
        end
    end

endmodule
`default_nettype wire
